// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith ops,
// iterative shifts (one bit per cycle) and a shift-add multiplier.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             cf,
  output logic             nf,
  output logic             vf,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_AND = 4'd1, OP_NOT = 4'd2, OP_SUB = 4'd3, OP_OR = 4'd4,
    OP_XOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_MUL = 4'd8
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
  logic [SW:0]      cnt_q;

  // Single-cycle result, computed straight from the offered operands.
  logic [WIDTH:0]   sum, diff;
  logic [SW-1:0]    n;
  logic [WIDTH-1:0] r_y;
  logic             r_c, r_v, r_err, go_exec;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign n    = b[SW-1:0];

  always_comb begin
    r_y   = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    r_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        r_y = sum[WIDTH-1:0];
        r_c = sum[WIDTH];
        r_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r_y = a & b;
      OP_NOT: r_y = ~a;
      OP_SUB: begin
        r_y = diff[WIDTH-1:0];
        r_c = diff[WIDTH];
        r_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  r_y = a | b;
      OP_XOR: r_y = a ^ b;
      OP_SHL, OP_SHR: r_y = a;
      OP_MUL: r_y = '0;
      default: r_err = 1'b1;
    endcase
  end

  assign go_exec = (((opcode == OP_SHL) || (opcode == OP_SHR)) && (n != '0))
                || (opcode == OP_MUL);

  // Iteration step: lo_q is the shift register for SHL/SHR and the low
  // product half / multiplier for MUL (right-shifting shift-add).
  logic [WIDTH-1:0] sh_lo, mul_hi, mul_lo, fin_y;
  logic             sh_c, fin_c, last;
  logic [WIDTH:0]   mul_sum;

  always_comb begin
    if (op_q == OP_SHL) {sh_c, sh_lo} = {lo_q, 1'b0};
    else                {sh_lo, sh_c} = {1'b0, lo_q};
  end

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign fin_y   = (op_q == OP_MUL) ? mul_lo : sh_lo;
  assign fin_c   = (op_q == OP_MUL) ? (mul_hi != '0) : sh_c;
  assign last    = (cnt_q == (SW+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      nf        <= 1'b0;
      vf        <= 1'b0;
      err       <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      op_q      <= OP_ADD;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (go_exec) begin
            state   <= EXEC;
            op_q    <= op_t'(opcode);
            hi_q    <= '0;
            lo_q    <= (opcode == OP_MUL) ? b : a;
            mcand_q <= a;
            cnt_q   <= (opcode == OP_MUL) ? (SW+1)'(WIDTH) : {1'b0, n};
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= r_y;
            zf        <= (r_y == '0);
            nf        <= r_y[WIDTH-1];
            cf        <= r_c;
            vf        <= r_v;
            err       <= r_err;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - (SW+1)'(1);
          if (op_q == OP_MUL) begin
            hi_q <= mul_hi;
            lo_q <= mul_lo;
          end else begin
            lo_q <= sh_lo;
          end
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= fin_y;
            zf        <= (fin_y == '0);
            nf        <= fin_y[WIDTH-1];
            cf        <= fin_c;
            vf        <= 1'b0;
            err       <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (WIDTH=8) plus hand-written
// reset-abort and backpressure sequences.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   opcode;
  logic [W-1:0] a, b, y;
  logic         zf, cf, nf, vf, err;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zf(zf), .cf(cf), .nf(nf), .vf(vf),
    .err(err)
  );

  always #5 clk = ~clk;

  // fl = {zf, cf, nf, vf, err}
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] y;
    logic [4:0]   fl;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {zf, cf, nf, vf, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    opcode   = v.op;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    opcode   = 4'($urandom);
    k = 1;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(k), 32'(v.lat));
    chk($sformatf("v%0d_y", idx), 32'(y), 32'(v.y));
    chk($sformatf("v%0d_flags", idx), 32'(flags()), 32'(v.fl));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("v%0d_return_idle", idx), 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int  k;
    logic seen;

    //          op     a      b      lat y      zcnve
    vecs[0]  = '{4'd0, 8'h7F, 8'h01, 1, 8'h80, 5'b00110};
    vecs[1]  = '{4'd0, 8'hFF, 8'h01, 1, 8'h00, 5'b11000};
    vecs[2]  = '{4'd3, 8'h03, 8'h05, 1, 8'hFE, 5'b01100};
    vecs[3]  = '{4'd3, 8'h80, 8'h01, 1, 8'h7F, 5'b00010};
    vecs[4]  = '{4'd6, 8'h81, 8'h03, 4, 8'h08, 5'b00000};
    vecs[5]  = '{4'd7, 8'h81, 8'h01, 2, 8'h40, 5'b01000};
    vecs[6]  = '{4'd6, 8'h81, 8'h08, 1, 8'h81, 5'b00100};
    vecs[7]  = '{4'd8, 8'h10, 8'h11, 9, 8'h10, 5'b01000};
    vecs[8]  = '{4'd12, 8'hFF, 8'h00, 1, 8'h00, 5'b10001};
    vecs[9]  = '{4'd1, 8'hF0, 8'h0F, 1, 8'h00, 5'b10000};
    vecs[10] = '{4'd2, 8'h5A, 8'h00, 1, 8'hA5, 5'b00100};
    vecs[11] = '{4'd4, 8'h0A, 8'h50, 1, 8'h5A, 5'b00000};
    vecs[12] = '{4'd5, 8'hFF, 8'h0F, 1, 8'hF0, 5'b00100};
    vecs[13] = '{4'd8, 8'h0F, 8'h0F, 9, 8'hE1, 5'b00100};
    vecs[14] = '{4'd7, 8'hFF, 8'h17, 8, 8'h01, 5'b01000};
    vecs[15] = '{4'd0, 8'h80, 8'h80, 1, 8'h00, 5'b11010};
    vecs[16] = '{4'd3, 8'h05, 8'h05, 1, 8'h00, 5'b10000};
    vecs[17] = '{4'd8, 8'hFF, 8'hFF, 9, 8'h01, 5'b01000};
    vecs[18] = '{4'd6, 8'h01, 8'h07, 8, 8'h80, 5'b00100};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_handshake", 32'({in_ready, out_valid}), 32'b10);
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_flags", 32'(flags()), 32'd0);

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a multiply must abort it silently.
    opcode = 4'd8; a = 8'h10; b = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mul_exec_busy", 32'({in_ready, out_valid}), 32'b00);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("abort_handshake", 32'({in_ready, out_valid}), 32'b10);
    chk("abort_y", 32'(y), 32'd0);
    chk("abort_flags", 32'(flags()), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_late_result", 32'(seen), 32'd0);

    // Multiply held under backpressure while a new request waits.
    opcode = 4'd8; a = 8'h10; b = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("bp_latency", 32'(k), 32'd9);
    opcode = 4'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i),
          32'({in_ready, out_valid, y, flags()}), 32'({1'b0, 1'b1, 8'h10, 5'b01000}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_released", 32'({in_ready, out_valid}), 32'b10);
    tick();
    in_valid = 1'b0;
    chk("bp_next_op", 32'({out_valid, y, flags()}), 32'({1'b1, 8'h02, 5'b00000}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_final_idle", 32'({in_ready, out_valid}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the team's 8-bit combinational ALU. It accepts one operation at a time over a valid/ready handshake. Single-cycle ops complete in one clock; shifts and multiply iterate internally. Each result is held, with a full flag set, until the consumer takes it. It sits between the CPU decode/register-read stage and writeback, and adds carry, negative and overflow flags to the zero flag.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 4.
- SW, $clog2(WIDTH), width of the shift-amount field taken from b[SW-1:0]; derived, do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- opcode  in  4  operation select.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand; b[SW-1:0] is the shift amount for SHL/SHR.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- y  out  WIDTH  result.
- zf  out  1  zero flag.
- cf  out  1  carry / borrow / last bit shifted out.
- nf  out  1  negative flag, y[WIDTH-1].
- vf  out  1  signed overflow flag.
- err  out  1  undefined opcode was executed.

## Operation
Opcodes:
- 0 ADD: a+b.
- 1 AND: a&b.
- 2 NOT: ~a.
- 3 SUB: a-b.
- 4 OR: a|b.
- 5 XOR: a^b.
- 6 SHL: a logical-left by n = b[SW-1:0].
- 7 SHR: a logical-right by n.
- 8 MUL: low WIDTH bits of a*b, computed by unsigned shift-add.
- 9-15: undefined.

Operands and opcode are captured into internal registers on accept. Later changes on a, b or opcode have no effect until the next accept.

FSM states:
- IDLE: in_ready=1. Accept (in_valid && in_ready) goes to DONE for single-cycle ops, for SHL/SHR with n=0, and for undefined opcodes. Accept goes to EXEC for SHL/SHR with n>0 and for MUL.
- EXEC: SHL/SHR shift one bit per cycle, decrementing a counter from n. MUL performs one shift-add step per cycle for WIDTH cycles. When the counter reaches 0, go to DONE.
- DONE: out_valid=1 and outputs are stable. When out_ready is high, go to IDLE.

Flags:
- zf = (y==0) for every opcode, including undefined.
- ADD: cf = carry out of bit WIDTH-1. vf = 1 when a and b have the same sign and y differs from it.
- SUB: cf = borrow (1 when a<b unsigned). vf = 1 when a and b have different signs and y's sign differs from a's.
- SHL/SHR: cf = last bit shifted out; cf=0 when n=0. vf=0.
- MUL: cf = 1 when the high half of the 2·WIDTH product is nonzero. vf=0.
- Logic ops (AND, OR, XOR, NOT): cf=0, vf=0.
- nf = y[WIDTH-1] for all defined ops.
- Undefined opcode: y=0, zf=1, cf=nf=vf=0, err=1. err=0 for all defined ops.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, y=0, zf=0, cf=0, nf=0, vf=0, err=0, iteration counter 0.
- rst is sampled on the clk edge and overrides everything. Reset asserted mid-EXEC or in DONE aborts the operation. The pending result is discarded, with no out_valid pulse.
- Latency is measured from the accept edge to the first cycle with out_valid=1:
  - Single-cycle ops, undefined opcodes, and shifts with n=0: 1 cycle.
  - SHL/SHR: n+1 cycles.
  - MUL: WIDTH+1 cycles.
- in_ready is low from the accept edge until the edge on which DONE completes, so there is no overlap.
- Turnaround: the first cycle after a DONE completion is IDLE. A back-to-back single-cycle throughput is one op per 2 cycles.
- out_valid stays high and y/flags stay frozen while out_ready=0. There is no timeout.
- in_valid while in_ready=0 is ignored. The source must hold the request until accepted.
- Shift amounts are modulo WIDTH: only b[SW-1:0] is used, and upper b bits are ignored.

## Test plan
- Reset: assert rst for 2 cycles during a MUL in EXEC -> out_valid=0, in_ready=1, all outputs 0 the cycle after release; no result appears later.
- ADD overflow (WIDTH=8): a=0x7F, b=0x01 -> after 1 cycle y=0x80, nf=1, vf=1, cf=0, zf=0. ADD a=0xFF, b=0x01 -> y=0x00, zf=1, cf=1, vf=0.
- SUB borrow: a=0x03, b=0x05 -> y=0xFE, cf=1, nf=1, vf=0. a=0x80, b=0x01 -> y=0x7F, vf=1.
- Shifts: SHL a=0x81, b=0x03 -> out_valid exactly 4 cycles after accept, y=0x08, cf=0. SHR a=0x81, b=0x01 -> 2 cycles, y=0x40, cf=1. SHL b=0x08 (n=0) -> 1 cycle, y=0x81, cf=0.
- MUL and backpressure: a=0x10, b=0x11, out_ready=0 for 5 cycles after out_valid -> out_valid at cycle 9, y=0x10, cf=1, held stable. in_valid with new ops during this time is not accepted until the cycle after out_ready=1.
- Undefined opcode 12 with a=0xFF -> after 1 cycle y=0, zf=1, err=1. The following AND 0xF0&0x0F -> y=0, zf=1, err=0.
